// File: rtl/led_if.sv
// Pattern engine bus: mode/pause controls toward the engine, LED drive and
// step strobe back out.
interface led_if #(
  parameter int LED_W = 4
);
  logic [1:0]       mode;
  logic             pause;
  logic [LED_W-1:0] led;
  logic             step;

  modport master (output mode, output pause, input led, input step);
  modport slave  (input mode, input pause, output led, output step);
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled step ticks advance flow/bounce/blink/count.
// Optional LED_ACTIVE_LOW_EN drives led = ~pat for current-sinking boards.
//
// mode_q      | meaning
// MODE_FLOW   | single lit LED rotating toward MSB, wrapping to bit 0
// MODE_BOUNCE | single lit LED sweeping MSB-ward then back, ends lit once
// MODE_BLINK  | whole bank toggles between all-off and all-on
// MODE_COUNT  | binary up-count, modulo 2^LED_W
module led_pattern_gen #(
  parameter int LED_W    = 4,
  parameter int STEP_CYC = 25_000_000
) (
  input logic  clk,
  input logic  rst_n,
  led_if.slave bus
);

  localparam int CNT_W = $clog2(STEP_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYC - 1);

  typedef enum logic [1:0] {
    MODE_FLOW   = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  logic [CNT_W-1:0] cnt, cnt_d;
  logic [LED_W-1:0] pat, pat_d;
  mode_e            mode_q, mode_d;
  logic             dir, dir_d;
  logic             step_q, step_d;
  logic             tick, mode_chg;
  logic [LED_W-1:0] shl, shr;

  assign tick     = (cnt == CNT_LAST) && !bus.pause;
  assign mode_chg = (bus.mode != mode_q);
  assign shl      = pat << 1;
  assign shr      = pat >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      pat    <= LED_W'(1);
      mode_q <= MODE_FLOW;
      dir    <= 1'b0;
      step_q <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      pat    <= pat_d;
      mode_q <= mode_d;
      dir    <= dir_d;
      step_q <= step_d;
    end
  end

  always_comb begin
    cnt_d  = cnt;
    pat_d  = pat;
    mode_d = mode_q;
    dir_d  = dir;
    step_d = 1'b0;
    // A mode change wins over a coincident tick and ignores pause.
    if (mode_chg) begin
      mode_d = mode_e'(bus.mode);
      cnt_d  = '0;
      dir_d  = 1'b0;
      case (mode_e'(bus.mode))
        MODE_FLOW, MODE_BOUNCE: pat_d = LED_W'(1);
        default:                pat_d = '0;
      endcase
    end else if (!bus.pause) begin
      cnt_d = tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        step_d = 1'b1;
        case (mode_q)
          MODE_FLOW:  pat_d = {pat[LED_W-2:0], pat[LED_W-1]};
          MODE_BOUNCE: begin
            if (!dir) begin
              pat_d = shl;
              dir_d = shl[LED_W-1];
            end else begin
              pat_d = shr;
              dir_d = !shr[0];
            end
          end
          MODE_BLINK: pat_d = ~pat;
          MODE_COUNT: pat_d = pat + LED_W'(1);
          default:    pat_d = pat;
        endcase
      end
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign bus.led = ~pat;
`else
  assign bus.led = pat;
`endif
  assign bus.step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: step-index reference model plus
// pinned literal sequences, followed by randomized mode/pause/reset traffic.
module tb_led_pattern_gen;

  localparam int LED_W    = 4;
  localparam int STEP_CYC = 4;

  logic clk = 1'b0;
  logic rst_n;

  led_if #(.LED_W(LED_W)) bus ();

  led_pattern_gen #(.LED_W(LED_W), .STEP_CYC(STEP_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: pattern is a pure function of mode and steps since it was loaded.
  int   m_mode = 0;
  int   m_k    = 0;
  int   m_ph   = 0;
  logic m_step = 1'b0;

  function automatic logic [LED_W-1:0] phys(input logic [LED_W-1:0] p);
`ifdef LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  function automatic logic [LED_W-1:0] model_pat(input int md, input int k);
    int per, i, pos;
    per = 2 * LED_W - 2;
    case (md)
      0: return LED_W'(1 << (k % LED_W));
      1: begin
        i   = k % per;
        pos = (i < LED_W) ? i : per - i;
        return LED_W'(1 << pos);
      end
      2: return (k % 2 == 1) ? {LED_W{1'b1}} : '0;
      default: return LED_W'(k % (1 << LED_W));
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_k    <= 0;
      m_ph   <= 0;
      m_step <= 1'b0;
    end else if (int'(bus.mode) != m_mode) begin
      m_mode <= int'(bus.mode);
      m_k    <= 0;
      m_ph   <= 0;
      m_step <= 1'b0;
    end else if (bus.pause) begin
      m_step <= 1'b0;
    end else if (m_ph == STEP_CYC - 1) begin
      m_ph   <= 0;
      m_k    <= m_k + 1;
      m_step <= 1'b1;
    end else begin
      m_ph   <= m_ph + 1;
      m_step <= 1'b0;
    end
  end

  // Pinned literal expectation for the sample after the next clock edge.
  string           pin_name = "";
  logic [LED_W-1:0] pin_led  = '0;
  logic            pin_step = 1'b0;
  int              pin_id   = 0;
  int              pin_seen = 0;

  task automatic chk(input string nm, input logic [LED_W-1:0] act,
                     input logic [LED_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk or negedge rst_n) begin
    #1;
    chk("model_led", bus.led, phys(model_pat(m_mode, m_k)));
    chk("model_step", {3'b000, bus.step}, {3'b000, m_step});
    if (!rst_n) begin
      chk("reset_led", bus.led, phys(LED_W'(1)));
      chk("reset_step", {3'b000, bus.step}, 4'b0000);
    end else if (pin_id != pin_seen) begin
      chk({pin_name, "_led"}, bus.led, phys(pin_led));
      chk({pin_name, "_step"}, {3'b000, bus.step}, {3'b000, pin_step});
      pin_seen = pin_id;
    end
  end

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) nxt();
  endtask

  task automatic expect_next(input string nm, input logic [LED_W-1:0] l,
                             input logic s);
    pin_name = nm;
    pin_led  = l;
    pin_step = s;
    pin_id++;
    nxt();
  endtask

  // Three quiet edges holding prev, then the step edge showing nv.
  task automatic expect_step(input string nm, input logic [LED_W-1:0] prev,
                             input logic [LED_W-1:0] nv);
    repeat (STEP_CYC - 1) expect_next({nm, "_hold"}, prev, 1'b0);
    expect_next(nm, nv, 1'b1);
  endtask

  logic [LED_W-1:0] flow_seq   [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [LED_W-1:0] bounce_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                       4'b0010, 4'b0001, 4'b0010};
  logic [LED_W-1:0] blink_seq  [4] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};

  initial begin
    logic [LED_W-1:0] prev;
    rst_n     = 1'b0;
    bus.mode  = 2'd0;
    bus.pause = 1'b0;
    idle(10);
    rst_n = 1'b1;

    prev = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      expect_step("flow", prev, flow_seq[s]);
      prev = flow_seq[s];
    end

    rst_n    = 1'b0;
    bus.mode = 2'd1;
    idle(10);
    rst_n = 1'b1;
    expect_next("bounce_load", 4'b0001, 1'b0);
    prev = 4'b0001;
    for (int s = 0; s < 7; s++) begin
      expect_step("bounce", prev, bounce_seq[s]);
      prev = bounce_seq[s];
    end

    bus.mode = 2'd2;
    expect_next("blink_load", 4'b0000, 1'b0);
    prev = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      expect_step("blink", prev, blink_seq[s]);
      prev = blink_seq[s];
    end

    bus.mode = 2'd3;
    expect_next("count_load", 4'b0000, 1'b0);
    prev = 4'b0000;
    for (int s = 1; s <= 21; s++) begin
      expect_step((s == 16) ? "count_wrap" : "count", prev, LED_W'(s % 16));
      prev = LED_W'(s % 16);
    end

    expect_next("pre_pause", 4'b0101, 1'b0);
    expect_next("pre_pause", 4'b0101, 1'b0);
    bus.pause = 1'b1;
    repeat (10) expect_next("pause_hold", 4'b0101, 1'b0);
    bus.pause = 1'b0;
    expect_next("resume_wait", 4'b0101, 1'b0);
    expect_next("resume_step", 4'b0110, 1'b1);

    bus.mode = 2'd0;
    expect_next("race_flow_load", 4'b0001, 1'b0);
    repeat (3) expect_next("race_flow_hold", 4'b0001, 1'b0);
    bus.mode = 2'd3;
    expect_next("race_change", 4'b0000, 1'b0);
    expect_step("race_step", 4'b0000, 4'b0001);

    bus.mode = 2'd1;
    expect_next("bounce_reload", 4'b0001, 1'b0);
    prev = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      expect_step("bounce_pre_rst", prev, bounce_seq[s]);
      prev = bounce_seq[s];
    end
    rst_n = 1'b0;
    idle(10);
    rst_n = 1'b1;

    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) bus.pause = ~bus.pause;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
      end
      nxt();
    end
    bus.pause = 1'b0;
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine for the board LED bank: an internal prescaler divides the system clock into step ticks, and on each tick one of four selectable patterns advances (flow, bounce, blink, binary count). It supersedes the fixed 4-LED flow-light block, adding generic LED width and step period, run-time mode selection, pause, and a step strobe for downstream logic. It sits directly between the top-level clock/reset and the LED pins.

## Interface
- `LED_W`, 4, number of LEDs; legal values are 2 and above.
- `STEP_CYC`, 25_000_000, clock cycles per pattern step. The default gives 0.5 s at 50 MHz. Legal values are 2 and above.
- `clk`  in  1  system clock, 50 MHz (20 ns).
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  2  pattern select: 0 flow, 1 bounce, 2 blink, 3 count. Synchronous to `clk`.
- `pause`  in  1  while high, the prescaler and pattern are frozen.
- `led`  out  LED_W  LED drive, taken straight from the pattern register with no extra stage.
- `step`  out  1  one-cycle strobe, high in the cycle in which the new pattern first appears on `led`.

## Operation
- **State held:**
  - prescaler `cnt`, width $clog2(STEP_CYC)
  - pattern `pat[LED_W-1:0]`
  - registered mode `mode_q`
  - bounce direction `dir` (0 = toward MSB)
  - strobe register `step`
- **Reset values:** `cnt`=0, `pat`=1, `mode_q`=0, `dir`=0, `step`=0. So `led`=0…01 after reset, with the macro absent.
- **Tick condition:** `cnt==STEP_CYC-1` and `pause==0`.
- **Ordinary cycle:** `cnt` increments, or wraps to 0 on a tick.
- **Mode change:** when `mode != mode_q`, on that edge:
  - `mode_q` takes `mode` and `cnt` is set to 0.
  - `pat` and `dir` load the init value for the new mode: flow 0…01; bounce 0…01 with `dir`=0; blink all-0; count all-0.
  - `step` is not asserted.
  - A mode change takes priority over a tick on the same edge.
  - A mode change is applied even while `pause` is high.
- **Advance on a tick:** on a tick edge, `pat` advances according to `mode_q`:
  - **Flow:** rotate left, with bit LED_W-1 wrapping to bit 0.
  - **Bounce:**
    - If `dir`=0, shift left; if the result has bit LED_W-1 set, set `dir`=1.
    - If `dir`=1, shift right; if the result has bit 0 set, set `dir`=0.
    - The end LEDs are lit for one step only. For LED_W=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - **Blink:** `pat` becomes `~pat`.
  - **Count:** `pat` becomes `pat+1` modulo 2^LED_W, wrapping from all-1 to all-0.
- **Step strobe:** `step` is a registered copy of the tick condition, excluding edges that perform a mode change.
- **Pause:** `cnt`, `pat` and `dir` hold, and `step` stays 0. On release, counting resumes from the held `cnt` value.
- **Reset mid-operation:** all state returns to its reset value immediately (asynchronous). Counting restarts from 0 after `rst_n` rises.

## Timing
- Step period is exactly STEP_CYC cycles when unpaused.
- **After reset release:** the first tick edge is the STEP_CYC-th rising edge after `rst_n` deasserts, with `mode` held at 0.
- **After a mode change:** the first new-mode step comes STEP_CYC edges after the change edge.
- **Held mode input at reset release:** if `mode` is not 0 at reset release, the first edge performs a mode change. That delays the first step by one cycle.
- `led` and `step` update on the same edge; both are glitch-free register outputs.
- Mode change to init pattern: visible one edge after `mode` changes.
- **Input handling:** `mode` and `pause` are sampled every edge, with no debounce. The source must be synchronous to `clk`.

## Configuration
- **`LED_ACTIVE_LOW_EN`:**
  - **Defined:** `led` = `~pat`, for boards that sink LED current. Reset drives `led` to 1…10, and all-off patterns drive all-1.
  - **Undefined:** `led` = `pat` (active-high).
  - `step`, `cnt` and the internal behaviour are identical in both cases.

## Test plan
Bench parameters: LED_W=4, STEP_CYC=4, 20 ns clock, `rst_n` low for 10 cycles.

- **Reset and flow, mode 0:** `led` must be 0001 during reset. It then steps 0010, 0100, 1000, 0001 every 4 cycles, with `step` high for exactly 1 cycle each time.
- **Bounce, mode 1 from reset:**
  - The first edge loads 0001.
  - Required sequence: 0010, 0100, 1000, 0100, 0010, 0001, 0010.
  - No pattern may repeat at the ends.
- **Blink and count:**
  - Mode 2 must alternate 1111 and 0000.
  - Mode 3 must count 0000 through 1111, then wrap to 0000 on the 16th step.
- **Pause:** assert `pause` for 10 cycles mid-count at `pat`=0101.
  - `led` must stay 0101 and `step` must stay 0.
  - The next step must come exactly (4 − `cnt` at pause) cycles after release.
- **Mode change racing a tick:** switch flow→count on the same edge as `cnt`=3.
  - `led` must become 0000 with no `step`.
  - The next `step` must come 4 cycles later with `led`=0001.
- **Async reset mid-bounce:** drop `rst_n` between edges while `led`=0100 and `dir`=1.
  - `led` must go to 0001 immediately, before the next edge.
  - `step` must go to 0.
  - Rerun with `LED_ACTIVE_LOW_EN` defined: `led` must read 1110.
